cycle_sequencer: RTL and testbench

//   Instruction-cycle controller for the Q2 CPU. Sequences the flip-flop-based registers
//   (IR, PC, MA, ACC) through fetch / decode / indirect / execute, issuing one-cycle load strobes.

---
 rtl/cycle_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_cycle_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_sequencer.sv
// cycle_sequencer
//   Instruction-cycle controller for the Q2 CPU. Walks the IR/PC/MA/ACC
//   registers through FETCH -> DECODE -> (INDIR) -> EXEC, issues the one-cycle
//   load strobes, owns the memory request handshake with a wait-state
//   watchdog, and implements front-panel run/halt control.
//
//   Optional feature macro: CYCLE_STEP_EN
//     When defined, a one-cycle 'step' pulse in HALT (run=0, no bus error)
//     executes exactly one instruction and then returns to HALT.
//     When undefined, 'step' is ignored and only 'run' leaves HALT.
module cycle_sequencer #(
    parameter int WAIT_LIMIT = 15,
    parameter int WAIT_BITS  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic       indirect,
    input  logic       is_store,
    input  logic       halt_req,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_ma,
    output logic       ld_acc,
    output logic [2:0] state,
    output logic       halted,
    output logic       bus_err
);

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_INDIR  = 3'd3,
        S_EXEC   = 3'd4
    } state_t;

    // Count value on which an unanswered request trips the watchdog: the
    // count holds the number of earlier unanswered cycles, so the trip
    // happens on the WAIT_LIMIT-th request cycle without an ack.
    localparam logic [WAIT_BITS-1:0] LIMIT_LAST = WAIT_BITS'(WAIT_LIMIT - 1);

    state_t               r_state;
    state_t               w_nextState;
    state_t               w_boundary;
    logic [WAIT_BITS-1:0] r_waitCnt;
    logic                 r_busErr;
    logic                 w_limitHit;
    logic                 w_setBusErr;
    logic                 w_stepActive;

`ifdef CYCLE_STEP_EN
    logic                 r_stepFlag;
    logic                 w_stepStart;

    assign w_stepActive = r_stepFlag;

    // Remember that the current instruction was launched by a step pulse so
    // the next instruction boundary parks the machine in HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stepFlag <= 1'b0;
        end else if (w_nextState == S_HALT) begin
            r_stepFlag <= 1'b0;
        end else if (w_stepStart) begin
            r_stepFlag <= 1'b1;
        end
    end
`else
    logic                 w_unusedStep;

    assign w_unusedStep = step;
    assign w_stepActive = 1'b0;
`endif

    assign w_limitHit = (r_waitCnt == LIMIT_LAST);
    assign w_boundary = (run && !w_stepActive) ? S_FETCH : S_HALT;

    // Current-state register; reset parks the machine in HALT immediately,
    // which also drops mem_req in the same instant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HALT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the combinational memory request and strobes.
    // An ack always wins over a watchdog trip in the same cycle.
    always_comb begin
        w_nextState = r_state;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ld_ir       = 1'b0;
        inc_pc      = 1'b0;
        ld_ma       = 1'b0;
        ld_acc      = 1'b0;
        w_setBusErr = 1'b0;
`ifdef CYCLE_STEP_EN
        w_stepStart = 1'b0;
`endif
        case (r_state)
            S_HALT: begin
                if (!r_busErr) begin
                    if (run) begin
                        w_nextState = S_FETCH;
                    end
`ifdef CYCLE_STEP_EN
                    else if (step) begin
                        w_nextState = S_FETCH;
                        w_stepStart = 1'b1;
                    end
`endif
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ld_ir       = 1'b1;
                    inc_pc      = 1'b1;
                    w_nextState = S_DECODE;
                end else if (w_limitHit) begin
                    w_setBusErr = 1'b1;
                    w_nextState = S_HALT;
                end
            end
            S_DECODE: begin
                ld_ma       = 1'b1;
                w_nextState = indirect ? S_INDIR : S_EXEC;
            end
            S_INDIR: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ld_ma       = 1'b1;
                    w_nextState = S_EXEC;
                end else if (w_limitHit) begin
                    w_setBusErr = 1'b1;
                    w_nextState = S_HALT;
                end
            end
            S_EXEC: begin
                if (halt_req) begin
                    w_nextState = S_HALT;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = is_store;
                    if (mem_ack) begin
                        ld_acc      = !is_store;
                        w_nextState = w_boundary;
                    end else if (w_limitHit) begin
                        w_setBusErr = 1'b1;
                        w_nextState = S_HALT;
                    end
                end
            end
            default: begin
                w_nextState = S_HALT;
            end
        endcase
    end

    // Watchdog: counts consecutive unanswered request cycles within one
    // state; any ack, state change or idle bus restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_waitCnt <= '0;
        end else if (!mem_req || mem_ack || (w_nextState != r_state)) begin
            r_waitCnt <= '0;
        end else begin
            r_waitCnt <= r_waitCnt + WAIT_BITS'(1);
        end
    end

    // Sticky bus error; only reset clears it, and it blocks leaving HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busErr <= 1'b0;
        end else if (w_setBusErr) begin
            r_busErr <= 1'b1;
        end
    end

    assign state   = r_state;
    assign halted  = (r_state == S_HALT);
    assign bus_err = r_busErr;

endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer
//   Self-checking bench for cycle_sequencer: a table of per-cycle vectors,
//   hand-written multi-cycle sequences, and a randomized run compared against
//   a behavioural model of the instruction cycle.
module tb_cycle_sequencer;

    localparam int WAIT_LIMIT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        step;
    logic        indirect;
    logic        is_store;
    logic        halt_req;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        ld_ir;
    logic        inc_pc;
    logic        ld_ma;
    logic        ld_acc;
    logic [2:0]  state;
    logic        halted;
    logic        bus_err;
    logic [10:0] w_dutVec;

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state (state codes are the architectural ones).
    int mSt;
    int mWait;
    bit mErr;
    bit mFlag;

    typedef struct {
        logic        rstV;
        logic        runV;
        logic        indV;
        logic        stoV;
        logic        hltV;
        logic        ackV;
        logic [10:0] expV;
    } vec_t;

    vec_t vecs[19];

    cycle_sequencer #(.WAIT_LIMIT(WAIT_LIMIT), .WAIT_BITS(8)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .indirect(indirect),
        .is_store(is_store), .halt_req(halt_req), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .ld_ir(ld_ir), .inc_pc(inc_pc),
        .ld_ma(ld_ma), .ld_acc(ld_acc), .state(state), .halted(halted),
        .bus_err(bus_err)
    );

    assign w_dutVec = {mem_req, mem_we, ld_ir, inc_pc, ld_ma, ld_acc, state, halted, bus_err};

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation still running, expected to finish");
        $fatal(1, "[TB] global timeout");
    end

    function automatic logic [10:0] ex(bit req, bit we, bit ir, bit pc, bit ma, bit acc,
                                       int st, bit hl, bit be);
        return {req, we, ir, pc, ma, acc, 3'(st), hl, be};
    endfunction

    function automatic vec_t mkRow(logic r, logic rn, logic ind, logic sto, logic hl,
                                   logic ack, logic [10:0] e);
        vec_t v;
        v.rstV = r; v.runV = rn; v.indV = ind; v.stoV = sto; v.hltV = hl; v.ackV = ack;
        v.expV = e;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rn, input logic st, input logic ind,
                                 input logic sto, input logic hl, input logic ack);
        rst = r; run = rn; step = st; indirect = ind; is_store = sto; halt_req = hl; mem_ack = ack;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        nextCycle();
    endtask

    // ---------------- behavioural model ----------------
    task automatic modelReset();
        mSt = 0; mWait = 0; mErr = 0; mFlag = 0;
    endtask

    // Does the current phase of the instruction talk to memory?
    function automatic bit modelReq();
        return (mSt == 1) || (mSt == 3) || (mSt == 4 && !halt_req);
    endfunction

    function automatic logic [10:0] modelOut();
        bit req  = modelReq();
        bit done = req && mem_ack;
        return ex(req, req && mSt == 4 && is_store, mSt == 1 && done, mSt == 1 && done,
                  mSt == 2 || (mSt == 3 && done), mSt == 4 && done && !is_store,
                  (mSt <= 4) ? mSt : 0, mSt == 0, mErr);
    endfunction

    task automatic modelAdvance();
        bit req      = modelReq();
        bit done     = req && mem_ack;
        bit timedOut = req && !mem_ack && (mWait + 1 >= WAIT_LIMIT);
        int nxt      = mSt;
        if (mSt == 0) begin
            if (!mErr && run) nxt = 1;
`ifdef CYCLE_STEP_EN
            else if (!mErr && step) begin
                nxt   = 1;
                mFlag = 1;
            end
`endif
        end else if (mSt == 2) begin
            nxt = indirect ? 3 : 4;
        end else if (mSt == 4 && halt_req) begin
            nxt = 0;
        end else if (done) begin
            nxt = (mSt == 1) ? 2 : (mSt == 3) ? 4 : ((run && !mFlag) ? 1 : 0);
        end else if (timedOut) begin
            nxt  = 0;
            mErr = 1;
        end
        mWait = (req && !mem_ack && nxt == mSt) ? mWait + 1 : 0;
        if (nxt == 0) mFlag = 0;
        mSt = nxt;
    endtask

    initial begin
        int reqCnt[8];
        int waitCnt, maPulses, weBad, weExec, irCnt, accCnt, stuck, ackPct;
        bit seenExec, finished, rV, rnV, sV, iV, stV, hV, aV;

        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        nextCycle();

        // ---------- table-driven vectors ----------
        vecs[0]  = mkRow(1, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs[1]  = mkRow(0, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs[2]  = mkRow(0, 1, 0, 0, 0, 1, ex(1, 0, 1, 1, 0, 0, 1, 0, 0));
        vecs[3]  = mkRow(0, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 2, 0, 0));
        vecs[4]  = mkRow(0, 1, 0, 0, 0, 1, ex(1, 0, 0, 0, 0, 1, 4, 0, 0));
        vecs[5]  = mkRow(0, 1, 0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs[6]  = mkRow(0, 1, 0, 0, 0, 1, ex(1, 0, 1, 1, 0, 0, 1, 0, 0));
        vecs[7]  = mkRow(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 1, 0, 2, 0, 0));
        vecs[8]  = mkRow(0, 0, 0, 0, 0, 1, ex(1, 0, 0, 0, 0, 1, 4, 0, 0));
        vecs[9]  = mkRow(0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs[10] = mkRow(0, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs[11] = mkRow(0, 1, 0, 0, 0, 1, ex(1, 0, 1, 1, 0, 0, 1, 0, 0));
        vecs[12] = mkRow(0, 1, 0, 0, 1, 0, ex(0, 0, 0, 0, 1, 0, 2, 0, 0));
        vecs[13] = mkRow(0, 1, 0, 0, 1, 1, ex(0, 0, 0, 0, 0, 0, 4, 0, 0));
        vecs[14] = mkRow(0, 1, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));
        vecs[15] = mkRow(0, 1, 0, 1, 0, 1, ex(1, 0, 1, 1, 0, 0, 1, 0, 0));
        vecs[16] = mkRow(0, 1, 0, 1, 0, 0, ex(0, 0, 0, 0, 1, 0, 2, 0, 0));
        vecs[17] = mkRow(0, 0, 0, 1, 0, 1, ex(1, 1, 0, 0, 0, 0, 4, 0, 0));
        vecs[18] = mkRow(0, 0, 0, 0, 0, 1, ex(0, 0, 0, 0, 0, 0, 0, 1, 0));

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].rstV, vecs[i].runV, 0, vecs[i].indV, vecs[i].stoV,
                          vecs[i].hltV, vecs[i].ackV);
            @(negedge clk);
            checkOutput($sformatf("vector_%0d", i), 32'(w_dutVec), 32'(vecs[i].expV));
            nextCycle();
        end

        // ---------- async reset in the middle of FETCH ----------
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("fetch_req_before_rst", 32'(mem_req), 32'd1);
        #1 rst = 1'b1;
        #1 checkOutput("async_rst_mid_fetch", 32'(w_dutVec), 32'(ex(0, 0, 0, 0, 0, 0, 0, 1, 0)));
        nextCycle();

        // ---------- indirect store, ack after 2 wait cycles ----------
        applyStimulus(0, 1, 0, 1, 1, 0, 0);
        nextCycle();
        for (int k = 0; k < 8; k++) reqCnt[k] = 0;
        waitCnt = 0; maPulses = 0; weBad = 0; weExec = 0; seenExec = 0; finished = 0;
        for (int c = 0; c < 40; c++) begin
            mem_ack = mem_req && (waitCnt == 2);
            @(negedge clk);
            if (mem_req) begin
                reqCnt[state]++;
                if (mem_we && state != 3'd4) weBad++;
                if (mem_we && state == 3'd4) weExec++;
            end
            if (ld_ma) maPulses++;
            if (mem_req && !mem_ack) waitCnt++;
            else waitCnt = 0;
            if (seenExec && halted) begin
                finished = 1;
                break;
            end
            if (state == 3'd4) begin
                seenExec = 1;
                run = 1'b0;
            end
            nextCycle();
        end
        checkOutput("indir_store_completes", 32'(finished), 32'd1);
        checkOutput("fetch_req_cycles", reqCnt[1], 32'd3);
        checkOutput("indir_req_cycles", reqCnt[3], 32'd3);
        checkOutput("exec_req_cycles", reqCnt[4], 32'd3);
        checkOutput("we_outside_exec", weBad, 32'd0);
        checkOutput("we_in_exec", weExec, 32'd3);
        checkOutput("ld_ma_pulses", maPulses, 32'd2);

        // ---------- watchdog: FETCH never acknowledged ----------
        doReset();
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        nextCycle();
        reqCnt[0] = 0; finished = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus_err) begin
                finished = 1;
                break;
            end
            if (mem_req) reqCnt[0]++;
            nextCycle();
        end
        checkOutput("watchdog_trips", 32'(finished), 32'd1);
        checkOutput("watchdog_req_cycles", reqCnt[0], WAIT_LIMIT);
        checkOutput("watchdog_halted_state", 32'(state), 32'd0);
        stuck = 0;
        for (int c = 0; c < 10; c++) begin
            nextCycle();
            @(negedge clk);
            if (state != 3'd0 || !bus_err || mem_req) stuck++;
        end
        checkOutput("bus_err_blocks_run", stuck, 32'd0);
        nextCycle();
        rst = 1'b1;
        #1 checkOutput("rst_clears_bus_err", 32'(bus_err), 32'd0);
        nextCycle();

        // ---------- ack on the cycle the watchdog would trip ----------
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        nextCycle();
        for (int c = 0; c < WAIT_LIMIT - 1; c++) nextCycle();
        mem_ack = 1'b1;
        @(negedge clk);
        checkOutput("ack_wins_ld_ir", 32'(ld_ir), 32'd1);
        nextCycle();
        mem_ack = 1'b0;
        @(negedge clk);
        checkOutput("ack_wins_state", 32'({state, bus_err}), 32'({3'd2, 1'b0}));

        // ---------- single step ----------
        doReset();
`ifdef CYCLE_STEP_EN
        applyStimulus(0, 0, 1, 0, 0, 0, 1);
        nextCycle();
        step = 1'b0;
        irCnt = 0; accCnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ld_ir) irCnt++;
            if (ld_acc) accCnt++;
            step = (state == 3'd4);
            nextCycle();
        end
        step = 1'b0;
        @(negedge clk);
        checkOutput("step_one_fetch", irCnt, 32'd1);
        checkOutput("step_one_exec", accCnt, 32'd1);
        checkOutput("step_ends_halted", 32'(state), 32'd0);
`else
        applyStimulus(0, 0, 1, 0, 0, 0, 1);
        stuck = 0;
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            @(negedge clk);
            if (state != 3'd0) stuck++;
        end
        checkOutput("step_ignored", stuck, 32'd0);
`endif

        // ---------- randomized run against the behavioural model ----------
        doReset();
        modelReset();
        ackPct = 80;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                case ((c / 250) % 3)
                    0:       ackPct = 80;
                    1:       ackPct = 35;
                    default: ackPct = 4;
                endcase
            end
            rV  = ($urandom_range(0, 149) == 0);
            rnV = ($urandom_range(0, 9) != 0);
            sV  = ($urandom_range(0, 9) == 0);
            iV  = $urandom_range(0, 1) != 0;
            stV = $urandom_range(0, 1) != 0;
            hV  = ($urandom_range(0, 5) == 0);
            aV  = ($urandom_range(0, 99) < ackPct);
            applyStimulus(rV, rnV, sV, iV, stV, hV, aV);
            if (rV) modelReset();
            @(negedge clk);
            checkOutput($sformatf("random_cycle_%0d", c), 32'(w_dutVec), 32'(modelOut()));
            if (!rV) modelAdvance();
            nextCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
